cam_bien_san_pham: RTL and testbench

//  Product-sensor front end for the product/box counter: the producing end of its count interface.

---
 rtl/cam_bien_san_pham_pkg.sv | 15 +
 rtl/cam_bien_san_pham_dong_bo_2ff.sv | 26 ++
 rtl/cam_bien_san_pham.sv | 97 +++++++++
 tb/tb_cam_bien_san_pham.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_bien_san_pham_pkg.sv
// Shared definitions for the product-sensor front end: FSM state encoding and default timing.
package cam_bien_san_pham_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_PRESENT = 3'd2,
        ST_RELEASE = 3'd3,
        ST_JAM     = 3'd4
    } state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_JAM_CYCLES      = 20;

endpackage

// File: rtl/cam_bien_san_pham_dong_bo_2ff.sv
// Two-flop synchronizer for asynchronous board pins; both stages reset to 0.
module dong_bo_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_ff1;
    logic [WIDTH-1:0] r_ff2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ff1 <= '0;
            r_ff2 <= '0;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end

    assign o_q = r_ff2;

endmodule

// File: rtl/cam_bien_san_pham.sv
// Light-barrier front end: debounces the beam, emits one pulse per product,
// runs the belt and halts it on a jam until an operator clears it.
module cam_bien_san_pham
    import cam_bien_san_pham_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int JAM_CYCLES      = DEF_JAM_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sensor_raw,
    input  logic i_stop,
    input  logic i_jam_clr,
    output logic o_product_pulse,
    output logic o_product_present,
    output logic o_conveyor_run,
    output logic o_jam
);

    localparam int CW = $clog2(JAM_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] JAM_LAST = CW'(JAM_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic          w_sensor_s;
    state_e        r_state;
    state_e        w_next;
    logic          w_cnt_inc;
    logic [CW-1:0] r_cnt;

    dong_bo_2ff #(.WIDTH(1)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_sensor_raw),
        .o_q     (w_sensor_s)
    );

    // A falling sensor always wins over a terminal count in the same cycle.
    always_comb begin
        w_next    = r_state;
        w_cnt_inc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sensor_s) w_next = ST_ARM;
            end
            ST_ARM: begin
                if (!w_sensor_s)           w_next = ST_IDLE;
                else if (r_cnt == DEB_LAST) w_next = ST_PRESENT;
                else                        w_cnt_inc = 1'b1;
            end
            ST_PRESENT: begin
                if (!w_sensor_s) w_next = ST_RELEASE;
                else if (!i_stop) begin
                    if (r_cnt == JAM_LAST) w_next = ST_JAM;
                    else                   w_cnt_inc = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (w_sensor_s)             w_next = ST_PRESENT;
                else if (r_cnt == DEB_LAST) w_next = ST_IDLE;
                else                        w_cnt_inc = 1'b1;
            end
            ST_JAM: begin
                if (i_jam_clr && !w_sensor_s) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)                 r_cnt <= '0;
            else if (w_cnt_inc && r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_product_pulse   <= 1'b0;
            o_product_present <= 1'b0;
            o_conveyor_run    <= 1'b0;
            o_jam             <= 1'b0;
        end else begin
            o_product_pulse   <= (r_state == ST_ARM) && (w_next == ST_PRESENT);
            o_product_present <= (w_next == ST_PRESENT) || (w_next == ST_RELEASE) ||
                                 (w_next == ST_JAM);
            o_conveyor_run    <= !i_stop && (w_next != ST_JAM);
            o_jam             <= (w_next == ST_JAM);
        end
    end

endmodule

// File: tb/tb_cam_bien_san_pham.sv
// Bench for the product-sensor front end: directed scenarios plus random beam/stop/clear
// traffic compared against a run-length behavioural model.
module tb_cam_bien_san_pham;

    localparam int D = 4;
    localparam int J = 20;

    logic clk;
    logic rst_n;
    logic sensor_raw;
    logic stop;
    logic jam_clr;
    logic product_pulse;
    logic product_present;
    logic conveyor_run;
    logic jam;

    cam_bien_san_pham #(.DEBOUNCE_CYCLES(D), .JAM_CYCLES(J)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_sensor_raw      (sensor_raw),
        .i_stop            (stop),
        .i_jam_clr         (jam_clr),
        .o_product_pulse   (product_pulse),
        .o_product_present (product_present),
        .o_conveyor_run    (conveyor_run),
        .o_jam             (jam)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    wire [3:0] obs = {product_pulse, product_present, conveyor_run, jam};

    // Model: beam level seen two edges late, judged by run lengths of that level.
    bit         m_s1, m_s2;
    int         hi_run, lo_run, belt;
    bit         beam, jammed;
    logic [3:0] m_exp;

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0;
        hi_run = 0; lo_run = 0; belt = 0;
        beam = 0; jammed = 0;
        m_exp = 4'b0000;
    endfunction

    function automatic void model_edge(input bit raw, input bit stp, input bit clr);
        bit s;
        bit pulse;
        s     = m_s2;
        m_s2  = m_s1;
        m_s1  = raw;
        pulse = 0;
        if (jammed) begin
            if (clr && !s) begin
                jammed = 0; beam = 0; hi_run = 0; lo_run = 0;
            end
        end else if (!beam) begin
            if (s) begin
                hi_run++;
                if (hi_run == D + 1) begin
                    beam = 1; pulse = 1; hi_run = 0; lo_run = 0; belt = 0;
                end
            end else begin
                hi_run = 0;
            end
        end else if (!s) begin
            lo_run++;
            if (lo_run == D + 1) begin
                beam = 0; lo_run = 0; hi_run = 0;
            end
        end else if (lo_run > 0) begin
            lo_run = 0; belt = 0;
        end else if (!stp) begin
            belt++;
            if (belt == J) begin
                jammed = 1; beam = 0; belt = 0;
            end
        end
        m_exp = {pulse, beam || jammed, !stp && !jammed, jammed};
    endfunction

    task automatic cyc(input bit raw, input bit stp, input bit clr);
        sensor_raw = raw;
        stop       = stp;
        jam_clr    = clr;
        @(posedge clk);
        if (rst_n) model_edge(raw, stp, clr);
        else       model_reset();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; sensor_raw = 0; stop = 0; jam_clr = 0;
        model_reset();
        #2;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            n_chk++;
            if (obs !== 4'b0000) $display("FAIL reset cyc%0d: got %b want 0000", i, obs);
            else n_pass++;
        end
        rst_n = 1;
        cyc(0, 0, 0);
        n_chk++;
        if (obs !== 4'b0010) $display("FAIL reset_release: got %b want 0010", obs);
        else n_pass++;
    endtask

    task automatic test_clean();
        int npulse = 0;
        int pidx   = -1;
        for (int i = 0; i < 20; i++) begin
            cyc(i < 10, 0, 0);
            n_chk++;
            if (obs !== m_exp) $display("FAIL clean cyc%0d: got %b want %b", i, obs, m_exp);
            else n_pass++;
            if (product_pulse) begin npulse++; pidx = i; end
        end
        n_chk++;
        if (npulse != 1 || pidx != 2 + D) $display("FAIL clean_pulse: got %0d pulses at %0d want 1 at %0d", npulse, pidx, 2 + D);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int seen = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(i < 3, 0, 0);
            n_chk++;
            if (obs !== m_exp) $display("FAIL glitch cyc%0d: got %b want %b", i, obs, m_exp);
            else n_pass++;
            if (product_pulse || product_present) seen++;
        end
        n_chk++;
        if (seen != 0 || obs !== 4'b0010) $display("FAIL glitch_none: got %0d active cycles, outputs %b want 0 and 0010", seen, obs);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit pat[$];
        int npulse = 0;
        for (int i = 0; i < 8; i++) pat.push_back(1);
        for (int c = 0; c < 5; c++) begin
            pat.push_back(c[0] ? 1'b1 : 1'b0);
            pat.push_back(c[0] ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 12; i++) pat.push_back(0);
        foreach (pat[i]) begin
            cyc(pat[i], 0, 0);
            n_chk++;
            if (obs !== m_exp) $display("FAIL bounce cyc%0d: got %b want %b", i, obs, m_exp);
            else n_pass++;
            if (product_pulse) npulse++;
        end
        n_chk++;
        if (npulse != 1 || product_present !== 1'b0) $display("FAIL bounce_total: got %0d pulses present=%b want 1 and 0", npulse, product_present);
        else n_pass++;
    endtask

    task automatic test_jam();
        int jidx = -1;
        for (int i = 0; i < 30; i++) begin
            cyc(1, 0, 0);
            n_chk++;
            if (obs !== m_exp) $display("FAIL jam cyc%0d: got %b want %b", i, obs, m_exp);
            else n_pass++;
            if (jam && jidx < 0) jidx = i;
        end
        n_chk++;
        if (jidx != 2 + D + J) $display("FAIL jam_time: got %0d want %0d", jidx, 2 + D + J);
        else n_pass++;
        cyc(1, 0, 1);
        n_chk++;
        if (obs !== 4'b0101) $display("FAIL jam_clr_ignored: got %b want 0101", obs);
        else n_pass++;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        cyc(0, 0, 1);
        n_chk++;
        if (obs !== 4'b0010) $display("FAIL jam_cleared: got %b want 0010", obs);
        else n_pass++;
        n_chk++;
        if (obs !== m_exp) $display("FAIL jam_model: got %b want %b", obs, m_exp);
        else n_pass++;
    endtask

    task automatic test_stopped();
        int npulse = 0;
        int njam   = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(i < 40, 1, 0);
            n_chk++;
            if (obs !== m_exp) $display("FAIL stopped cyc%0d: got %b want %b", i, obs, m_exp);
            else n_pass++;
            if (product_pulse) npulse++;
            if (jam || conveyor_run) njam++;
        end
        n_chk++;
        if (npulse != 1 || njam != 0) $display("FAIL stopped_summary: got %0d pulses %0d jam/run cycles want 1 and 0", npulse, njam);
        else n_pass++;
        cyc(0, 0, 0);
        n_chk++;
        if (conveyor_run !== 1'b1) $display("FAIL stopped_resume: got run=%b want 1", conveyor_run);
        else n_pass++;
    endtask

    task automatic test_reset_mid_arm();
        int npulse = 0;
        for (int i = 0; i < 4; i++) cyc(1, 0, 0);
        rst_n = 0;
        #1;
        n_chk++;
        if (obs !== 4'b0000) $display("FAIL async_reset: got %b want 0000", obs);
        else n_pass++;
        model_reset();
        cyc(0, 0, 0);
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0);
            n_chk++;
            if (obs !== m_exp) $display("FAIL post_reset cyc%0d: got %b want %b", i, obs, m_exp);
            else n_pass++;
            if (product_pulse) npulse++;
        end
        for (int i = 0; i < 16; i++) begin
            cyc(i < 10, 0, 0);
            if (product_pulse) npulse++;
        end
        n_chk++;
        if (npulse != 1) $display("FAIL post_reset_product: got %0d pulses want 1", npulse);
        else n_pass++;
    endtask

    task automatic test_random();
        bit lvl = 0;
        bit stp = 0;
        int left = 0;
        for (int i = 0; i < 600; i++) begin
            if (left == 0) begin
                lvl  = ~lvl;
                left = (lvl && $urandom_range(0, 5) == 0) ? $urandom_range(20, 35)
                                                          : $urandom_range(1, 10);
                if ($urandom_range(0, 3) == 0) stp = ~stp;
            end
            left--;
            cyc(lvl, stp, $urandom_range(0, 7) == 0);
            n_chk++;
            if (obs !== m_exp) $display("FAIL random cyc%0d: got %b want %b", i, obs, m_exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_glitch();
        test_back_to_back();
        test_jam();
        test_stopped();
        test_reset_mid_arm();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
